// File: rtl/mag_ext_trk.sv
// ---------------------------------------------------------------------------
// mag_cmp
//   Unsigned magnitude comparator: grt_o = (a_i > b_i), lst_o = (a_i < b_i).
//
//   Ports:
//     a_i, b_i  [WIDTH-1:0]  operands, unsigned
//     grt_o                  a_i strictly greater than b_i
//     lst_o                  a_i strictly less than b_i
//
//   IMPLEMENTATION = 0 : chunked compare. Operands are zero-padded up to
//                        SPLIT equal chunks, each chunk is compared on its
//                        own, and the results are combined MSB chunk first.
//                        The chunk compares are independent and shallow,
//                        which keeps the critical path short on wide words.
//   IMPLEMENTATION != 0: flat relational compare, left to the synthesis tool.
// ---------------------------------------------------------------------------
module mag_cmp #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             grt_o,
    output logic             lst_o
);

    generate
        if (IMPLEMENTATION != 0) begin : g_flat
            assign grt_o = (a_i > b_i);
            assign lst_o = (a_i < b_i);
        end else begin : g_tree
            localparam int NCH = (SPLIT < 1) ? 1 : SPLIT;
            localparam int CW  = (WIDTH + NCH - 1) / NCH;
            localparam int PW  = CW * NCH;

            // Zero padding on the top keeps non-multiple widths correct:
            // the padded bits are equal in both operands.
            logic [PW-1:0]  a_pad;
            logic [PW-1:0]  b_pad;
            logic [NCH-1:0] chunk_gt;
            logic [NCH-1:0] chunk_lt;
            logic [NCH-1:0] chain_gt;
            logic [NCH-1:0] chain_lt;

            assign a_pad = PW'(a_i);
            assign b_pad = PW'(b_i);

            for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
                assign chunk_gt[gi] = (a_pad[gi*CW +: CW] > b_pad[gi*CW +: CW]);
                assign chunk_lt[gi] = (a_pad[gi*CW +: CW] < b_pad[gi*CW +: CW]);
            end

            // A chunk decides the result unless it is equal, in which case
            // the decision of the chunks below it is passed up.
            assign chain_gt[0] = chunk_gt[0];
            assign chain_lt[0] = chunk_lt[0];
            for (genvar gi = 1; gi < NCH; gi++) begin : g_chain
                assign chain_gt[gi] = chunk_gt[gi] |
                                      (~chunk_gt[gi] & ~chunk_lt[gi] & chain_gt[gi-1]);
                assign chain_lt[gi] = chunk_lt[gi] |
                                      (~chunk_gt[gi] & ~chunk_lt[gi] & chain_lt[gi-1]);
            end

            assign grt_o = chain_gt[NCH-1];
            assign lst_o = chain_lt[NCH-1];
        end
    endgenerate

endmodule

// ---------------------------------------------------------------------------
// mag_ext_trk
//   Per-frame extrema tracker. Accepts a stream of unsigned samples framed
//   by in_lst, and for each frame reports the largest and smallest sample,
//   the index of the first occurrence of each, the beat count (saturating)
//   and an overflow flag when the frame was longer than the counter range.
//
//   Ports:
//     clk, rst                clock, asynchronous active-high reset
//     in_vld/in_rdy           input handshake
//     in_val [WIDTH-1:0]      input sample
//     in_lst                  last beat of frame
//     out_vld/out_rdy         result handshake
//     out_max, out_min        frame extrema        [WIDTH-1:0]
//     out_imx, out_imn        first-occurrence idx [CNT_W-1:0]
//     out_cnt                 beat count, saturating [CNT_W-1:0]
//     out_ovf                 frame longer than 2^CNT_W-1 beats
//
//   The result is held in OUT until consumed; input is stalled meanwhile,
//   so every frame costs at least one bubble cycle.
// ---------------------------------------------------------------------------
module mag_ext_trk #(
    parameter int WIDTH          = 32,
    parameter int CNT_W          = 16,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_val,
    input  logic             in_lst,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_imx,
    output logic [CNT_W-1:0] out_imn,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] IDX_MAX = '1;
    localparam logic [CNT_W-1:0] IDX_ONE = CNT_W'(1);

    state_t           state_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    logic [CNT_W-1:0] imx_q;
    logic [CNT_W-1:0] imn_q;
    logic [CNT_W-1:0] idx_q;
    logic             ovf_q;
    logic             vld_q;

    logic             idx_sat;
    logic [CNT_W-1:0] idx_d;
    logic             accept;
    logic             new_max;
    logic             new_min;
    logic             max_lt_unused;
    logic             min_gt_unused;
    logic             unused_cmp;

    mag_cmp #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_cmp_max (
        .a_i   (in_val),
        .b_i   (max_q),
        .grt_o (new_max),
        .lst_o (max_lt_unused)
    );

    mag_cmp #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_cmp_min (
        .a_i   (in_val),
        .b_i   (min_q),
        .grt_o (min_gt_unused),
        .lst_o (new_min)
    );

    assign unused_cmp = max_lt_unused & min_gt_unused;

    // idx_q is both the index of the next beat and the running beat count.
    // It sticks at IDX_MAX so indices and count never wrap.
    assign idx_sat = (idx_q == IDX_MAX);
    assign idx_d   = idx_sat ? idx_q : (idx_q + IDX_ONE);

    // in_rdy is gated by rst so it reads 0 for the whole reset pulse.
    assign in_rdy  = ~rst & (state_q != S_OUT);
    assign accept  = in_vld & in_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            max_q   <= '0;
            min_q   <= '0;
            imx_q   <= '0;
            imn_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        max_q <= in_val;
                        min_q <= in_val;
                        imx_q <= '0;
                        imn_q <= '0;
                        idx_q <= IDX_ONE;
                        ovf_q <= 1'b0;
                        if (in_lst) begin
                            state_q <= S_OUT;
                            vld_q   <= 1'b1;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        // Strict compares: ties keep the earliest index.
                        if (new_max) begin
                            max_q <= in_val;
                            imx_q <= idx_q;
                        end
                        if (new_min) begin
                            min_q <= in_val;
                            imn_q <= idx_q;
                        end
                        idx_q <= idx_d;
                        if (idx_sat) begin
                            ovf_q <= 1'b1;
                        end
                        if (in_lst) begin
                            state_q <= S_OUT;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_rdy) begin
                        state_q <= S_IDLE;
                        vld_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_vld = vld_q;
    assign out_max = max_q;
    assign out_min = min_q;
    assign out_imx = imx_q;
    assign out_imn = imn_q;
    assign out_cnt = idx_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_mag_ext_trk.sv
// ---------------------------------------------------------------------------
// tb_mag_ext_trk
//   Directed bench for mag_ext_trk. Three instances share clk/rst:
//     A: WIDTH=8, defaults otherwise (chunked comparator, SPLIT=2)
//     B: WIDTH=8, CNT_W=3, flat comparator (count saturation)
//     C: WIDTH=5, SPLIT=4 (width not a multiple of the split)
//   Inputs change #1 after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_mag_ext_trk;

    logic clk;
    logic rst;

    logic       a_ivld, a_irdy, a_ilst, a_ovld, a_ordy, a_ovf;
    logic [7:0] a_ival, a_max, a_min;
    logic [15:0] a_imx, a_imn, a_cnt;

    logic       b_ivld, b_irdy, b_ilst, b_ovld, b_ordy, b_ovf;
    logic [7:0] b_ival, b_max, b_min;
    logic [2:0] b_imx, b_imn, b_cnt;

    logic       c_ivld, c_irdy, c_ilst, c_ovld, c_ordy, c_ovf;
    logic [4:0] c_ival, c_max, c_min;
    logic [15:0] c_imx, c_imn, c_cnt;

    int total;
    int bad;

    mag_ext_trk #(.WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_vld(a_ivld), .in_rdy(a_irdy), .in_val(a_ival), .in_lst(a_ilst),
        .out_vld(a_ovld), .out_rdy(a_ordy),
        .out_max(a_max), .out_min(a_min), .out_imx(a_imx), .out_imn(a_imn),
        .out_cnt(a_cnt), .out_ovf(a_ovf)
    );

    mag_ext_trk #(.WIDTH(8), .CNT_W(3), .IMPLEMENTATION(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_vld(b_ivld), .in_rdy(b_irdy), .in_val(b_ival), .in_lst(b_ilst),
        .out_vld(b_ovld), .out_rdy(b_ordy),
        .out_max(b_max), .out_min(b_min), .out_imx(b_imx), .out_imn(b_imn),
        .out_cnt(b_cnt), .out_ovf(b_ovf)
    );

    mag_ext_trk #(.WIDTH(5), .SPLIT(4)) dut_c (
        .clk(clk), .rst(rst),
        .in_vld(c_ivld), .in_rdy(c_irdy), .in_val(c_ival), .in_lst(c_ilst),
        .out_vld(c_ovld), .out_rdy(c_ordy),
        .out_max(c_max), .out_min(c_min), .out_imx(c_imx), .out_imn(c_imn),
        .out_cnt(c_cnt), .out_ovf(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [31:0] v, input logic lst);
        a_ivld = 1'b1; a_ival = v[7:0]; a_ilst = lst;
        tick();
        a_ivld = 1'b0; a_ival = 8'hEE; a_ilst = 1'b1;
    endtask

    task automatic beat_b(input logic [31:0] v, input logic lst);
        b_ivld = 1'b1; b_ival = v[7:0]; b_ilst = lst;
        tick();
        b_ivld = 1'b0; b_ival = 8'hEE; b_ilst = 1'b1;
    endtask

    task automatic beat_c(input logic [31:0] v, input logic lst);
        c_ivld = 1'b1; c_ival = v[4:0]; c_ilst = lst;
        tick();
        c_ivld = 1'b0; c_ival = 5'h1F; c_ilst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a_ivld = 1'b0; a_ival = '0; a_ilst = 1'b0; a_ordy = 1'b0;
        b_ivld = 1'b0; b_ival = '0; b_ilst = 1'b0; b_ordy = 1'b0;
        c_ivld = 1'b0; c_ival = '0; c_ilst = 1'b0; c_ordy = 1'b0;

        // Reset state
        #2;
        chk("rst_a_vld", {31'd0, a_ovld}, 32'd0);
        chk("rst_a_rdy", {31'd0, a_irdy}, 32'd0);
        chk("rst_a_max", {24'd0, a_max}, 32'd0);
        chk("rst_a_cnt", {16'd0, a_cnt}, 32'd0);
        chk("rst_b_ovf", {31'd0, b_ovf}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #2;
        chk("post_rst_a_rdy", {31'd0, a_irdy}, 32'd1);
        chk("post_rst_a_vld", {31'd0, a_ovld}, 32'd0);
        tick();

        // A: frame 5,9,2,9,2 with an idle cycle carrying garbage + lst
        beat_a(5, 1'b0);
        beat_a(9, 1'b0);
        tick();                       // in_vld=0, in_val=EE, in_lst=1 ignored
        chk("a_acc_vld", {31'd0, a_ovld}, 32'd0);
        chk("a_acc_rdy", {31'd0, a_irdy}, 32'd1);
        beat_a(2, 1'b0);
        beat_a(9, 1'b0);
        chk("a_acc_vld2", {31'd0, a_ovld}, 32'd0);
        beat_a(2, 1'b1);
        chk("a_f1_vld", {31'd0, a_ovld}, 32'd1);
        chk("a_f1_max", {24'd0, a_max}, 32'd9);
        chk("a_f1_imx", {16'd0, a_imx}, 32'd1);
        chk("a_f1_min", {24'd0, a_min}, 32'd2);
        chk("a_f1_imn", {16'd0, a_imn}, 32'd2);
        chk("a_f1_cnt", {16'd0, a_cnt}, 32'd5);
        chk("a_f1_ovf", {31'd0, a_ovf}, 32'd0);
        chk("a_f1_rdy", {31'd0, a_irdy}, 32'd0);

        // A: back-pressure with in_vld held high for 10 cycles
        a_ivld = 1'b1; a_ival = 8'h77; a_ilst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("a_hold_vld", {31'd0, a_ovld}, 32'd1);
        chk("a_hold_rdy", {31'd0, a_irdy}, 32'd0);
        chk("a_hold_max", {24'd0, a_max}, 32'd9);
        chk("a_hold_min", {24'd0, a_min}, 32'd2);
        chk("a_hold_imx", {16'd0, a_imx}, 32'd1);
        chk("a_hold_cnt", {16'd0, a_cnt}, 32'd5);
        a_ordy = 1'b1;
        tick();                       // handshake edge; 0x77 not accepted
        a_ordy = 1'b0;
        a_ivld = 1'b0;
        chk("a_ack_vld", {31'd0, a_ovld}, 32'd0);
        chk("a_ack_rdy", {31'd0, a_irdy}, 32'd1);
        tick();
        chk("a_idle_vld", {31'd0, a_ovld}, 32'd0);

        // A: single-beat frame 0xFF
        beat_a(32'hFF, 1'b1);
        chk("a_s_vld", {31'd0, a_ovld}, 32'd1);
        chk("a_s_max", {24'd0, a_max}, 32'hFF);
        chk("a_s_min", {24'd0, a_min}, 32'hFF);
        chk("a_s_imx", {16'd0, a_imx}, 32'd0);
        chk("a_s_imn", {16'd0, a_imn}, 32'd0);
        chk("a_s_cnt", {16'd0, a_cnt}, 32'd1);
        tick();
        chk("a_s_rdy", {31'd0, a_irdy}, 32'd0);
        a_ordy = 1'b1;
        tick();
        a_ordy = 1'b0;
        chk("a_s_ack_vld", {31'd0, a_ovld}, 32'd0);

        // B: exactly 2^3-1 beats, no overflow
        beat_b(10, 1'b0); beat_b(20, 1'b0); beat_b(5, 1'b0); beat_b(20, 1'b0);
        beat_b(5, 1'b0);  beat_b(1, 1'b0);  beat_b(30, 1'b1);
        chk("b7_vld", {31'd0, b_ovld}, 32'd1);
        chk("b7_max", {24'd0, b_max}, 32'd30);
        chk("b7_imx", {29'd0, b_imx}, 32'd6);
        chk("b7_min", {24'd0, b_min}, 32'd1);
        chk("b7_imn", {29'd0, b_imn}, 32'd5);
        chk("b7_cnt", {29'd0, b_cnt}, 32'd7);
        chk("b7_ovf", {31'd0, b_ovf}, 32'd0);
        b_ordy = 1'b1; tick(); b_ordy = 1'b0;

        // B: 9 beats, max on the last beat -> index saturates at 7
        beat_b(3, 1'b0); beat_b(1, 1'b0); beat_b(4, 1'b0); beat_b(1, 1'b0);
        beat_b(5, 1'b0); beat_b(9, 1'b0); beat_b(2, 1'b0); beat_b(6, 1'b0);
        beat_b(200, 1'b1);
        chk("b9_vld", {31'd0, b_ovld}, 32'd1);
        chk("b9_max", {24'd0, b_max}, 32'd200);
        chk("b9_imx", {29'd0, b_imx}, 32'd7);
        chk("b9_min", {24'd0, b_min}, 32'd1);
        chk("b9_imn", {29'd0, b_imn}, 32'd1);
        chk("b9_cnt", {29'd0, b_cnt}, 32'd7);
        chk("b9_ovf", {31'd0, b_ovf}, 32'd1);
        b_ordy = 1'b1; tick(); b_ordy = 1'b0;

        // C: WIDTH=5 SPLIT=4, frame 31,0,16
        beat_c(31, 1'b0); beat_c(0, 1'b0); beat_c(16, 1'b1);
        chk("c1_vld", {31'd0, c_ovld}, 32'd1);
        chk("c1_max", {27'd0, c_max}, 32'd31);
        chk("c1_imx", {16'd0, c_imx}, 32'd0);
        chk("c1_min", {27'd0, c_min}, 32'd0);
        chk("c1_imn", {16'd0, c_imn}, 32'd1);
        chk("c1_cnt", {16'd0, c_cnt}, 32'd3);
        c_ordy = 1'b1; tick(); c_ordy = 1'b0;

        // C: compares that cross chunk boundaries (15=01111, 16=10000)
        beat_c(15, 1'b0); beat_c(16, 1'b0); beat_c(13, 1'b0); beat_c(12, 1'b1);
        chk("c2_max", {27'd0, c_max}, 32'd16);
        chk("c2_imx", {16'd0, c_imx}, 32'd1);
        chk("c2_min", {27'd0, c_min}, 32'd12);
        chk("c2_imn", {16'd0, c_imn}, 32'd3);
        c_ordy = 1'b1; tick(); c_ordy = 1'b0;

        // A: reset mid-frame after 3 beats, asserted between clock edges
        beat_a(7, 1'b0); beat_a(3, 1'b0); beat_a(8, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("mr_a_rdy", {31'd0, a_irdy}, 32'd0);
        chk("mr_a_vld", {31'd0, a_ovld}, 32'd0);
        chk("mr_a_max", {24'd0, a_max}, 32'd0);
        chk("mr_a_min", {24'd0, a_min}, 32'd0);
        chk("mr_a_cnt", {16'd0, a_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_a_vld2", {31'd0, a_ovld}, 32'd0);
        tick();
        beat_a(4, 1'b0);
        beat_a(1, 1'b1);
        chk("mr_f_vld", {31'd0, a_ovld}, 32'd1);
        chk("mr_f_max", {24'd0, a_max}, 32'd4);
        chk("mr_f_imx", {16'd0, a_imx}, 32'd0);
        chk("mr_f_min", {24'd0, a_min}, 32'd1);
        chk("mr_f_imn", {16'd0, a_imn}, 32'd1);
        chk("mr_f_cnt", {16'd0, a_cnt}, 32'd2);
        a_ordy = 1'b1; tick(); a_ordy = 1'b0;
        chk("mr_f_ack", {31'd0, a_ovld}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
